// File: rtl/adc_acq_pkg.sv
// Shared types and defaults for the ADC acquisition sequencer.
package adc_acq_pkg;

    localparam int DW_DEF = 14;
    localparam int CW_DEF = 16;

    // Trigger mode encodings; the reserved code 3 is folded into TRIG_IMM at start.
    localparam logic [1:0] TRIG_IMM  = 2'd0;
    localparam logic [1:0] TRIG_RISE = 2'd1;
    localparam logic [1:0] TRIG_FALL = 2'd2;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ARM          = 3'd1,
        WAIT_TRIG    = 3'd2,
        CAPTURE      = 3'd3,
        FINISH       = 3'd4,
        FINISH_ABORT = 3'd5
    } state_t;

endpackage

// File: rtl/adc_trig_detect.sv
// Level-crossing trigger on channel A. prev_a tracks the last valid sample while
// the sequencer is arming or waiting; trig_hit is a same-cycle flag so the
// triggering sample itself can be kept.
module adc_trig_detect
    import adc_acq_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          track,
    input  logic          armed,
    input  logic          in_valid,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] level,
    input  logic [1:0]    mode,
    output logic          trig_hit
);

    logic [DW-1:0] prev_a;
    logic          rise;
    logic          fall;

    // Remember the previous valid channel-A sample for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_a <= '0;
        end else if (track && in_valid) begin
            prev_a <= in_a;
        end
    end

    // Unsigned crossing compare, qualified by mode and by the waiting state.
    always_comb begin
        rise     = (prev_a < level) && (in_a >= level);
        fall     = (prev_a >= level) && (in_a < level);
        trig_hit = armed && in_valid &&
                   (((mode == TRIG_RISE) && rise) || ((mode == TRIG_FALL) && fall));
    end

endmodule

// File: rtl/adc_acq_sequencer.sv
// Acquisition sequencer: gates the ADC front-end, waits for start and an optional
// channel-A trigger, decimates, and forwards exactly n_samples pairs downstream.
module adc_acq_sequencer
    import adc_acq_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          CLK_65,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    trig_mode,
    input  logic [DW-1:0] trig_level,
    input  logic [CW-1:0] decim,
    input  logic [CW-1:0] n_samples,
    output logic          adc_enable,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic          in_valid,
    input  logic          in_otr_a,
    input  logic          in_otr_b,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic          out_valid,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [1:0]    ovr,
    output logic [CW-1:0] count
);

    state_t        state;
    logic [1:0]    mode_lat;
    logic [DW-1:0] level_lat;
    logic [CW-1:0] decim_lat;
    logic [CW-1:0] n_lat;
    logic [CW-1:0] phase;
    logic [CW-1:0] count_inc;
    logic          active;
    logic          tracking;
    logic          armed;
    logic          trig_hit;
    logic          keep;
    logic          last;
    logic [1:0]    ovr_hit;

    adc_trig_detect #(.DW(DW)) u_trig (
        .clk      (CLK_65),
        .rst_n    (reset_n),
        .track    (tracking),
        .armed    (armed),
        .in_valid (in_valid),
        .in_a     (in_a),
        .level    (level_lat),
        .mode     (mode_lat),
        .trig_hit (trig_hit)
    );

    // Decide whether the current input pair is kept and whether it is the final one.
    always_comb begin
        active    = (state == ARM) || (state == WAIT_TRIG) || (state == CAPTURE);
        tracking  = (state == ARM) || (state == WAIT_TRIG);
        armed     = (state == WAIT_TRIG);
        count_inc = count + CW'(1);
        ovr_hit   = {in_valid && in_otr_b, in_valid && in_otr_a};
        keep      = 1'b0;
        // count == n_lat only happens with n_samples = 0; nothing is ever kept then.
        if (count != n_lat) begin
            case (state)
                ARM:       keep = in_valid && (mode_lat == TRIG_IMM);
                WAIT_TRIG: keep = trig_hit;
                CAPTURE:   keep = in_valid && (phase == '0);
                default:   keep = 1'b0;
            endcase
        end
        last = keep && (count_inc == n_lat);
    end

    // Sequencer FSM with registered status, stream outputs, counters and decimator.
    always_ff @(posedge CLK_65 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            mode_lat   <= TRIG_IMM;
            level_lat  <= '0;
            decim_lat  <= '0;
            n_lat      <= '0;
            phase      <= '0;
            adc_enable <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            ovr        <= '0;
            count      <= '0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;

            if (active) begin
                ovr <= ovr | ovr_hit;
                if (keep) begin
                    out_a     <= in_a;
                    out_b     <= in_b;
                    out_valid <= 1'b1;
                    count     <= count_inc;
                end
                // The phase counter only moves on valid samples; the trigger sample is phase 0.
                if (keep || ((state == CAPTURE) && in_valid)) begin
                    phase <= (phase == decim_lat - CW'(1)) ? '0 : phase + CW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ARM;
                        busy       <= 1'b1;
                        adc_enable <= 1'b1;
                        count      <= '0;
                        ovr        <= '0;
                        phase      <= '0;
                        mode_lat   <= ((trig_mode == TRIG_RISE) || (trig_mode == TRIG_FALL))
                                      ? trig_mode : TRIG_IMM;
                        level_lat  <= trig_level;
                        decim_lat  <= (decim == '0) ? CW'(1) : decim;
                        n_lat      <= n_samples;
                    end
                end
                ARM, WAIT_TRIG, CAPTURE: begin
                    // Normal completion outranks a coincident abort.
                    if (((state == ARM) && (n_lat == '0)) || last) begin
                        state      <= FINISH;
                        adc_enable <= 1'b0;
                        done       <= 1'b1;
                    end else if (abort) begin
                        state      <= FINISH_ABORT;
                        adc_enable <= 1'b0;
                        aborted    <= 1'b1;
                    end else if (keep) begin
                        state <= CAPTURE;
                    end else if ((state == ARM) && in_valid) begin
                        state <= WAIT_TRIG;
                    end
                end
                FINISH, FINISH_ABORT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Bench for adc_acq_sequencer: table of acquisition vectors plus hand-written
// sequences for abort, over-range and reset corner cases. Expected pairs are
// queued at stimulus time and popped as out_valid strobes appear.
module tb_adc_acq_sequencer;

    localparam int DW = 14;
    localparam int CW = 16;
    localparam logic [DW-1:0] BMASK = 14'h2AAA;

    logic          CLK_65 = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    trig_mode = '0;
    logic [DW-1:0] trig_level = '0;
    logic [CW-1:0] decim = '0;
    logic [CW-1:0] n_samples = '0;
    logic          adc_enable;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          in_valid = 1'b0;
    logic          in_otr_a = 1'b0;
    logic          in_otr_b = 1'b0;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [1:0]    ovr;
    logic [CW-1:0] count;

    adc_acq_sequencer #(.DW(DW), .CW(CW)) dut (
        .CLK_65     (CLK_65),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .decim      (decim),
        .n_samples  (n_samples),
        .adc_enable (adc_enable),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_valid   (in_valid),
        .in_otr_a   (in_otr_a),
        .in_otr_b   (in_otr_b),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .ovr        (ovr),
        .count      (count)
    );

    always #5 CLK_65 = ~CLK_65;

    typedef struct {
        logic [1:0]          mode;
        logic [DW-1:0]       level;
        logic [CW-1:0]       dcm;
        logic [CW-1:0]       n;
        int                  a0;
        int                  step;
        int                  len;
        bit                  gap;
        int                  n_exp;
        logic [3:0][DW-1:0]  exp;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pair_t;

    pair_t exp_q[$];
    vec_t  vecs[8];
    int    n_chk = 0;
    int    n_fail = 0;
    int    done_cnt = 0;
    int    abort_cnt = 0;
    logic          last_vld = 1'b0;
    logic [DW-1:0] last_a = '0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endfunction

    function automatic vec_t mk(logic [1:0] mode, int level, int dcm, int n, int a0, int step,
                                int len, bit gap, int n_exp, int e0, int e1, int e2, int e3);
        vec_t v;
        v.mode   = mode;
        v.level  = DW'(level);
        v.dcm    = CW'(dcm);
        v.n      = CW'(n);
        v.a0     = a0;
        v.step   = step;
        v.len    = len;
        v.gap    = gap;
        v.n_exp  = n_exp;
        v.exp[0] = DW'(e0);
        v.exp[1] = DW'(e1);
        v.exp[2] = DW'(e2);
        v.exp[3] = DW'(e3);
        return v;
    endfunction

    // Output monitor: scoreboard pop on every strobe, pulse counting, input history.
    always @(negedge CLK_65) begin
        pair_t e;
        if (!reset_n) begin
            last_vld = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_a), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_a", 32'(out_a), 32'(e.a));
                    chk("out_b", 32'(out_b), 32'(e.b));
                    chk("out_latency", 32'({last_vld, last_a}), 32'({1'b1, e.a}));
                end
            end
            if (done)    done_cnt++;
            if (aborted) abort_cnt++;
            last_vld = in_valid;
            last_a   = in_a;
        end
    end

    task automatic tick();
        @(posedge CLK_65);
        #1;
    endtask

    task automatic push_exp(logic [DW-1:0] a);
        pair_t p;
        p.a = a;
        p.b = a ^ BMASK;
        exp_q.push_back(p);
    endtask

    // Pulse start with a configuration, then scramble the config inputs.
    task automatic do_start(logic [1:0] m, logic [DW-1:0] lvl, logic [CW-1:0] d, logic [CW-1:0] n);
        trig_mode  = m;
        trig_level = lvl;
        decim      = d;
        n_samples  = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        trig_mode  = ~m;
        trig_level = ~lvl;
        decim      = d + CW'(7);
        n_samples  = n + CW'(5);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("adc_enable_after_start", 32'(adc_enable), 32'd1);
    endtask

    // Drive len valid samples a0 + i*step, optionally with a gap cycle between each.
    task automatic stream(int a0, int step, int len, bit gap, int otr_a_at, int otr_b_at, int abort_at);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < len) begin
            if (gap && (cyc % 2 == 1)) begin
                in_valid = 1'b0;
                in_otr_a = 1'b0;
                in_otr_b = 1'b0;
                abort    = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_a     = DW'(a0 + i * step);
                in_b     = in_a ^ BMASK;
                in_otr_a = (i == otr_a_at);
                in_otr_b = (i == otr_b_at);
                abort    = (i == abort_at);
                i++;
            end
            cyc++;
            tick();
        end
        in_valid = 1'b0;
        in_otr_a = 1'b0;
        in_otr_b = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic run_vec(vec_t v, int idx);
        int d0;
        int a0c;
        d0  = done_cnt;
        a0c = abort_cnt;
        for (int k = 0; k < v.n_exp; k++) push_exp(v.exp[k]);
        do_start(v.mode, v.level, v.dcm, v.n);
        stream(v.a0, v.step, v.len, v.gap, -1, -1, -1);
        repeat (4) tick();
        chk($sformatf("v%0d_pairs_left", idx), 32'(exp_q.size()), 32'd0);
        chk($sformatf("v%0d_done_pulses", idx), 32'(done_cnt - d0), 32'd1);
        chk($sformatf("v%0d_abort_pulses", idx), 32'(abort_cnt - a0c), 32'd0);
        chk($sformatf("v%0d_count", idx), 32'(count), 32'(v.n_exp));
        chk($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d_adc_enable_end", idx), 32'(adc_enable), 32'd0);
        chk($sformatf("v%0d_ovr", idx), 32'(ovr), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int d0;
        int a0c;
        //             mode  lvl  dcm n  a0   step len gap nexp expected
        vecs[0] = mk(2'd0,    0, 1, 4,   0,   1, 10, 0, 4,    0,    1,    2, 3);
        vecs[1] = mk(2'd1, 1000, 1, 3, 990,   5,  5, 0, 3, 1000, 1005, 1010, 0);
        vecs[2] = mk(2'd0,    0, 3, 3,   0,   1, 21, 1, 3,    0,    3,    6, 0);
        vecs[3] = mk(2'd0,    0, 0, 3,   5,   1,  8, 0, 3,    5,    6,    7, 0);
        vecs[4] = mk(2'd2,  500, 2, 2, 520, -10,  8, 0, 2,  490,  470,    0, 0);
        vecs[5] = mk(2'd3,    0, 1, 2,   7,   1,  4, 0, 2,    7,    8,    0, 0);
        vecs[6] = mk(2'd0,    0, 1, 0,   0,   1,  4, 0, 0,    0,    0,    0, 0);
        vecs[7] = mk(2'd1,  100, 2, 2,  90,   4, 12, 1, 2,  102,  110,    0, 0);

        // Reset state
        #1 reset_n = 1'b0;
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_adc_enable", 32'(adc_enable), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst_done_aborted", 32'({done, aborted}), 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Abort while waiting for a rising crossing that never happens
        d0  = done_cnt;
        a0c = abort_cnt;
        do_start(2'd1, 14'd1000, 16'd1, 16'd4);
        stream(1000, 5, 6, 0, -1, -1, -1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_pulse", 32'(aborted), 32'd1);
        chk("abort_busy_still", 32'(busy), 32'd1);
        chk("abort_adc_enable", 32'(adc_enable), 32'd0);
        tick();
        chk("abort_busy_low", 32'(busy), 32'd0);
        chk("abort_pulse_width", 32'(aborted), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        repeat (2) tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_pulses", 32'(abort_cnt - a0c), 32'd1);

        // Abort coincident with the final kept sample: done wins
        d0  = done_cnt;
        a0c = abort_cnt;
        push_exp(14'd0);
        push_exp(14'd1);
        do_start(2'd0, 14'd0, 16'd1, 16'd2);
        stream(0, 1, 2, 0, -1, -1, 1);
        repeat (3) tick();
        chk("abort_last_done", 32'(done_cnt - d0), 32'd1);
        chk("abort_last_no_aborted", 32'(abort_cnt - a0c), 32'd0);
        chk("abort_last_count", 32'(count), 32'd2);
        chk("abort_last_pairs_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Over-range A pulsed during capture is sticky, then cleared by a new start
        d0  = done_cnt;
        a0c = abort_cnt;
        for (int k = 0; k < 4; k++) push_exp(DW'(k));
        do_start(2'd0, 14'd0, 16'd1, 16'd4);
        stream(0, 1, 6, 0, 2, -1, -1);
        repeat (3) tick();
        chk("ovr_done", 32'(done_cnt - d0), 32'd1);
        chk("ovr_sticky", 32'(ovr), 32'd1);
        do_start(2'd0, 14'd0, 16'd1, 16'd4);
        chk("ovr_cleared", 32'(ovr), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (2) tick();
        chk("ovr_arm_abort", 32'(abort_cnt - a0c), 32'd1);
        chk("ovr_arm_abort_busy", 32'(busy), 32'd0);
        exp_q.delete();

        // Asynchronous reset in the middle of a capture
        for (int k = 0; k < 4; k++) push_exp(DW'(k));
        do_start(2'd0, 14'd0, 16'd1, 16'd10);
        stream(0, 1, 4, 0, -1, 1, -1);
        @(negedge CLK_65);
        chk("midrst_pre_ovr", 32'(ovr), 32'd2);
        chk("midrst_pre_count", 32'(count), 32'd4);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_adc_enable", 32'(adc_enable), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_ovr", 32'(ovr), 32'd0);
        chk("midrst_out", 32'({out_a, out_b}), 32'd0);
        chk("midrst_flags", 32'({out_valid, done, aborted}), 32'd0);
        chk("midrst_pairs_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        run_vec(vecs[0], 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_acq_sequencer.md
Name: adc_acq_sequencer

Overview:
Sequences acquisitions from the dual-channel ADC front-end. The block gates the front-end enable, waits for a software start and an optional level trigger on channel A, decimates the stream, and forwards exactly N sample pairs downstream as a valid-qualified stream. It also reports busy/done status and sticky over-range flags. It sits between the ADC front-end output (data_canal_a/b, data_valid) and the processing chain, in the CLK_65 domain.

Parameters:
DW, 14, ADC sample width per channel
CW, 16, width of sample-count and decimation fields

Ports:
CLK_65  in  1  system/ADC clock, 65 MHz
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; arms an acquisition when idle
abort  in  1  single-cycle pulse; terminates the acquisition in progress
trig_mode  in  2  0=immediate, 1=rising edge on A, 2=falling edge on A, 3=reserved (treated as 0)
trig_level  in  DW  unsigned threshold compared against channel A
decim  in  CW  keep 1 of every decim samples; 0 is treated as 1
n_samples  in  CW  number of output pairs per acquisition; 0 completes immediately
adc_enable  out  1  drives the front-end enable input
in_a  in  DW  front-end channel A
in_b  in  DW  front-end channel B
in_valid  in  1  front-end data_valid
in_otr_a  in  1  ADC over-range A, aligned with in_a
in_otr_b  in  1  ADC over-range B, aligned with in_b
out_a  out  DW  captured channel A
out_b  out  DW  captured channel B
out_valid  out  1  one-cycle strobe per captured pair
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on abort completion
ovr  out  2  sticky {B,A} over-range flags; cleared on accepted start
count  out  CW  pairs emitted in the current/last acquisition

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters and previous-sample register 0.
- Configuration (trig_mode, trig_level, decim, n_samples) is latched on the accepted start. Changes to these inputs mid-acquisition are ignored.
- State machine:
  - IDLE: start → ARM. count, ovr, and decim phase clear; busy rises the next cycle. start while not IDLE is ignored.
  - ARM: adc_enable=1. Waits for the first in_valid, which loads prev_a. Next state is WAIT_TRIG, or CAPTURE when the mode is immediate. If n_samples=0, go directly to FINISH; no out_valid is produced.
  - WAIT_TRIG: on each in_valid, prev_a is updated.
    - Rising trigger: prev_a < level AND in_a >= level.
    - Falling trigger: prev_a >= level AND in_a < level.
    - The triggering sample is the first kept sample (decim phase 0).
  - CAPTURE: on each in_valid, the sample is kept when the phase counter = 0. The phase counter wraps at decim_eff-1.
    - Kept sample: out_a/out_b registered, out_valid=1 exactly one cycle after the in_valid cycle, count += 1.
    - When count reaches n_samples, go to FINISH. No further out_valid is produced.
  - FINISH: adc_enable=0, done=1 for one cycle, then IDLE. busy falls when IDLE is entered.
- Abort: in any non-IDLE state, abort moves to FINISH_ABORT, which deasserts adc_enable, pulses aborted (not done), then goes to IDLE. If abort and the final kept sample occur in the same cycle, the sample is emitted and done wins; aborted does not pulse. Abort in IDLE is ignored.
- ovr: bit set whenever in_valid & in_otr_x while in ARM/WAIT_TRIG/CAPTURE. Sticky until the next accepted start.
- Comparisons are unsigned, DW bits. count never exceeds n_samples and does not wrap.
- in_valid gaps are tolerated. The phase counter advances only on in_valid.
- Reset mid-acquisition: immediate return to the reset state; no done or aborted pulse.
- out_a/out_b hold their last value when out_valid=0.

Decomposition:
- Package adc_acq_pkg: state enum (IDLE, ARM, WAIT_TRIG, CAPTURE, FINISH, FINISH_ABORT), trig_mode constants (TRIG_IMM, TRIG_RISE, TRIG_FALL), DW/CW defaults.
- Sub-module adc_trig_detect: prev_a register, edge compare, and mode select; outputs a one-cycle trig_hit. Sequencer FSM, decimator, and counters stay in the top.

Test Plan:
- Immediate mode, decim=1, n_samples=4, continuous in_a=0..9 → out_a=0,1,2,3, each out_valid one cycle after input; done pulse; count=4; adc_enable low after.
- Rising trigger, level=1000, in_a ramp 990..1010 step 5 → first out_a=1000; trigger not fired on start-up sample alone; n_samples=3 gives 1000,1005,1010.
- decim=3, n_samples=3, in_a=0..20 with in_valid low every other cycle → out_a=0,3,6; decim=0 behaves as decim=1.
- Abort during WAIT_TRIG (no crossing) → aborted pulse, no done, count=0, busy low 2 cycles later. Abort coincident with the last kept sample → sample emitted, done=1, aborted=0.
- in_otr_a pulsed once during CAPTURE → ovr=2'b01 held through done; a new start clears it to 0.
- reset_n asserted mid-CAPTURE → all outputs 0 asynchronously; next start runs normally. n_samples=0 → done with no out_valid.
